parking_spot_allocator: RTL

Sequential front end that owns the per-spot occupancy vector of the lot. It serves car-arrival requests with a req/ack handshake by assigning the lowest-numbered free spot, then holds the entry gate open for a programmable time. It also applies departures reported by spot number. Its registered 8-bit `occupancy` output is the vector that the downstream capacity counter converts into parked/empty counts.

---
 rtl/psa_if.sv | 32 +++
 rtl/parking_spot_allocator.sv | 95 +++++++++
 2 files changed

// File: rtl/psa_if.sv
// Entry/departure handshake bundle for parking_spot_allocator.
// The err signal exists only when PSA_ERR_EN is defined.
interface psa_if;
  logic       arrive_req;
  logic       depart_valid;
  logic [2:0] depart_spot;
  logic       arrive_ack;
  logic [2:0] assigned_spot;
  logic       gate_open;
  logic       reject;
  logic       full;
  logic [7:0] occupancy;
`ifdef PSA_ERR_EN
  logic       err;
`endif

  modport master (
    output arrive_req, depart_valid, depart_spot,
`ifdef PSA_ERR_EN
    input  err,
`endif
    input  arrive_ack, assigned_spot, gate_open, reject, full, occupancy
  );

  modport slave (
    input  arrive_req, depart_valid, depart_spot,
`ifdef PSA_ERR_EN
    output err,
`endif
    output arrive_ack, assigned_spot, gate_open, reject, full, occupancy
  );
endinterface

// File: rtl/parking_spot_allocator.sv
// Lowest-free-spot allocator with a timed entry gate and departure handling.
// Define PSA_ERR_EN to add a sticky err flag for departures of already-free spots.
module parking_spot_allocator #(
  parameter int GATE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  psa_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GATE  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_occ;
  logic [2:0] r_spot;
  logic       r_reject;

  logic       w_full;
  logic       w_grant;
  logic       w_refuse;
  logic [2:0] w_low;
  logic [7:0] w_set;
  logic [7:0] w_clr;

  // Scan from the top so the last assignment is the lowest free index.
  always_comb begin
    w_low = '0;
    for (int i = 7; i >= 0; i--)
      if (!r_occ[i]) w_low = 3'(i);
  end

  assign w_full   = (r_occ == 8'hFF);
  assign w_grant  = (r_state == S_IDLE) && bus.arrive_req && !w_full;
  assign w_refuse = (r_state == S_IDLE) && bus.arrive_req &&  w_full;
  assign w_set    = w_grant          ? (8'd1 << w_low)           : 8'd0;
  assign w_clr    = bus.depart_valid ? (8'd1 << bus.depart_spot) : 8'd0;

  // Set is OR-ed after the clear so an allocation wins a same-bit collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= 8'h00;
    else        r_occ <= (r_occ & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_spot   <= 3'd0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= w_refuse;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_spot  <= w_low;
            r_state <= S_GRANT;
          end else if (w_refuse) begin
            r_state <= S_HOLD;
          end
        end
        S_GRANT: begin
          r_cnt   <= 8'(GATE_CYCLES);
          r_state <= S_GATE;
        end
        S_GATE: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= S_HOLD;
        end
        default: begin
          if (!bus.arrive_req) r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PSA_ERR_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_err <= 1'b0;
    else if (bus.depart_valid && !r_occ[bus.depart_spot]) r_err <= 1'b1;
  end
  assign bus.err = r_err;
`endif

  // Decoded from registered state, so both drop as soon as reset asserts.
  assign bus.arrive_ack    = (r_state == S_GRANT);
  assign bus.gate_open     = (r_state == S_GATE);
  assign bus.reject        = r_reject;
  assign bus.full          = w_full;
  assign bus.occupancy     = r_occ;
  assign bus.assigned_spot = r_spot;
endmodule
